// File: rtl/hdmi_period_scheduler.sv
// Video timing generator and TMDS period scheduler: h/v counters, syncs, DE and
// the per-clock CTRL/PREAMBLE/GUARD/VIDEO selection for the three TMDS encoders.
module hdmi_period_scheduler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CW       = 11
) (
    input  logic          clk_pixel,
    input  logic          reset,
    input  logic          enable,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [1:0]    period,
    output logic [3:0]    ctl,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic          line_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] PRE_BEG = CW'(H_TOTAL - 10);
    localparam logic [CW-1:0] GRD_BEG = CW'(H_TOTAL - 2);

    if (H_BP < 10) begin : g_bad_hbp
        $error("hdmi_period_scheduler: H_BP must be >= 10 to fit preamble and guard band");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
        $error("hdmi_period_scheduler: CW too small for H_TOTAL-1 / V_TOTAL-1");
    end

    typedef enum logic [1:0] {
        P_CTRL     = 2'd0,
        P_PREAMBLE = 2'd1,
        P_GUARD    = 2'd2,
        P_VIDEO    = 2'd3
    } period_e;

    logic [CW-1:0] h_q, h_d, v_q, v_d, nv;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          de_q, de_d, fs_q, fs_d, ls_q, ls_d;
    period_e       period_q, period_d;
    logic [3:0]    ctl_q, ctl_d;
    logic          hs_on, vs_on, nv_active;

    // Outputs are decoded from the next counter value so they line up with x/y.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (enable) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end

        nv        = (v_d == V_LAST) ? '0 : v_d + CW'(1);
        nv_active = (nv < V_ACT);
        hs_on     = (h_d >= HS_BEG) && (h_d < HS_END);
        vs_on     = (v_d >= VS_BEG) && (v_d < VS_END);

        hsync_d  = hs_on ? SYNC_POL : ~SYNC_POL;
        vsync_d  = vs_on ? SYNC_POL : ~SYNC_POL;
        de_d     = 1'b0;
        period_d = P_CTRL;
        ctl_d    = '0;
        fs_d     = 1'b0;
        ls_d     = 1'b0;

        if (enable) begin
            if (h_d < H_ACT && v_d < V_ACT) begin
                de_d     = 1'b1;
                period_d = P_VIDEO;
            end else if (nv_active && h_d >= PRE_BEG && h_d < GRD_BEG) begin
                period_d = P_PREAMBLE;
                ctl_d    = 4'b0001;
            end else if (nv_active && h_d >= GRD_BEG) begin
                period_d = P_GUARD;
            end
            ls_d = (h_d == '0);
            fs_d = (h_d == '0) && (v_d == '0);
        end

        // Parking on the last line makes the first frame get a full preamble.
        if (reset) begin
            h_d      = '0;
            v_d      = V_LAST;
            hsync_d  = ~SYNC_POL;
            vsync_d  = ~SYNC_POL;
            de_d     = 1'b0;
            period_d = P_CTRL;
            ctl_d    = '0;
            fs_d     = 1'b0;
            ls_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_pixel) begin
        h_q      <= h_d;
        v_q      <= v_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        de_q     <= de_d;
        period_q <= period_d;
        ctl_q    <= ctl_d;
        fs_q     <= fs_d;
        ls_q     <= ls_d;
    end

    assign x           = h_q;
    assign y           = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign period      = period_q;
    assign ctl         = ctl_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule
